anode_scan_ctrl: RTL
====================

Name: anode_scan_ctrl

Overview:
Time-multiplexed scan controller for a common-anode multi-digit 7-segment display. It shares one BCD_Decoder instance among N_DIGITS digits, one digit at a time. A ghost-suppression blank interval precedes each digit slot. Display data is double-buffered through a valid/ready load port and takes effect only at frame boundaries.

Parameters:
N_DIGITS, 4, number of digits scanned; legal range 2..8.
PRESCALE, 50000, clk cycles per digit slot (blank plus drive); must exceed BLANK_CYCLES.
BLANK_CYCLES, 500, cycles at the start of each slot with all anodes off; at least 1.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  reset, asynchronous, active-low
en  input  1  scan enable
in_data  input  4*N_DIGITS  packed BCD digits; nibble 0 = least significant, rightmost digit
in_valid  input  1  load request
in_ready  output  1  pending buffer empty; load accepted on in_valid && in_ready
anode_n  output  N_DIGITS  one-cold anode drive; 1 = off
seg  output  7  segment drive {G,F,E,D,C,B,A}; all-ones = blank
frame_start  output  1  one-cycle pulse on entry to slot 0

Behaviour:
- Reset state (asynchronous on rst_n low): state IDLE, digit index 0, slot counter 0, active and pending buffers 0, pending flag 0. Outputs: anode_n all ones, seg 7'h7F, in_ready 1, frame_start 0.
- FSM states are IDLE, BLANK and DRIVE. The slot counter has width $clog2(PRESCALE) and counts 0..PRESCALE-1 across one slot.
- IDLE -> BLANK with digit 0 and counter 0 when en = 1.
- BLANK -> DRIVE when counter = BLANK_CYCLES-1.
- DRIVE -> BLANK when counter = PRESCALE-1. The digit index increments and wraps N_DIGITS-1 -> 0.
- Any state -> IDLE on the cycle after en = 0. IDLE clears the digit index and counter, so re-enabling always restarts at digit 0.
- Output timing: anode_n, seg and frame_start are registers loaded on the same edge the FSM enters a state, so they always match the current state. There is no extra latency.
- In IDLE and BLANK: anode_n all ones and seg 7'h7F.
- In DRIVE: anode_n bit[idx] = 0 and all other bits 1. seg is the BCD_Decoder output for active nibble idx.
  - A nibble greater than 9 forces seg to 7'h7F; the anode is still asserted.
- Frame period is N_DIGITS*PRESCALE cycles.
- Load handshake:
  - in_data is captured into the pending buffer on in_valid && in_ready, which sets the pending flag.
  - in_ready = !pending, registered.
- Frame transfer: on every entry to BLANK with digit 0, whether from IDLE or from the wrap, if pending is set then active <= pending and pending is cleared. in_ready returns high on the following cycle.
- Simultaneous events:
  - A capture cannot coincide with a transfer, because in_ready is low whenever a transfer is possible.
  - A capture in the same cycle as entry to digit 0 with pending empty goes to the pending buffer and is shown at the next frame.
- in_valid held while in_ready is low has no effect. The data is not latched.
- frame_start pulses on every entry to digit 0 BLANK, including the first entry after enable.
- Reset mid-operation: outputs return immediately (asynchronously) to their reset values, and both buffers are lost.

Optional Feature:
LEADING_ZERO_BLANK_EN:
- When defined: a digit is suppressed if idx > 0, its active nibble is 0, and all higher-index nibbles are also 0. A suppressed digit keeps anode_n all ones and seg 7'h7F during its DRIVE. Digit 0 is never suppressed.
- When undefined: every digit is driven.
- Suppression is evaluated from the active buffer only.

Decomposition:
- Shared package (anode_pkg): FSM state encoding (IDLE=2'd0, BLANK=2'd1, DRIVE=2'd2), SEG_BLANK = 7'h7F, ANODE_OFF (all ones, function of N_DIGITS), and BCD_MAX = 4'd9.
- Sub-module: the existing BCD_Decoder, instantiated once, with its input muxed from the active buffer by digit index. No other sub-module.

Test Plan:
(Bench configuration: N_DIGITS=4, PRESCALE=8, BLANK_CYCLES=2.)
1. Assert rst_n low with en=1, then release -> anode_n=4'hF, seg=7'h7F, in_ready=1 during reset. Enabling after release gives frame_start on the first active cycle.
2. Load 16'h1234 while in IDLE, then raise en -> digit0 DRIVE on slot cycles 2..7 with anode_n=4'b1110 and seg=decode(4). Digit 3 shows anode_n=4'b0111 with decode(1). frame_start repeats every 32 cycles.
3. Load 16'h5678 at cycle 10 of a frame -> display stays 1234 until the next frame start (cycle 32), with in_ready low over cycles 11..32. The next frame shows 5678 and in_ready is 1 again at cycle 33.
4. Drop en during DRIVE of digit 2 -> next cycle anode_n=4'hF and seg=7'h7F. Re-enable -> frame_start and scan restarts at digit 0. Also pull rst_n low mid-DRIVE -> outputs reset without waiting for a clock edge.
5. Active nibble 4'hA at digit 1 -> during its DRIVE, anode_n=4'b1101 and seg=7'h7F.
6. With LEADING_ZERO_BLANK_EN defined: 16'h0042 -> digits 3 and 2 keep anode_n all ones in their slots. 16'h0000 -> only digit 0 is driven, showing decode(0). With the macro undefined, 16'h0042 drives all four digits.

Source files
------------

// File: rtl/anode_pkg.sv
// Shared definitions for the anode scan controller: FSM encoding, blank
// patterns and the BCD range limit.
package anode_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    DRIVE = 2'd2
  } scan_state_e;

  localparam logic [6:0] SEG_BLANK  = 7'h7F;
  localparam logic [3:0] BCD_MAX    = 4'd9;
  localparam int         MAX_DIGITS = 8;

  // All-anodes-off mask for an nDigits-wide display; callers truncate to width.
  function automatic logic [MAX_DIGITS-1:0] ANODE_OFF(input int nDigits);
    logic [MAX_DIGITS-1:0] mask;
    mask = '0;
    for (int i = 0; i < MAX_DIGITS; i++) begin
      if (i < nDigits) mask[i] = 1'b1;
    end
    return mask;
  endfunction

endpackage

// File: rtl/anode_scan_ctrl_bcd_decoder.sv
// Active-low BCD to 7-segment decoder, output ordered {G,F,E,D,C,B,A}.
// Codes above nine produce a blank digit.
module BCD_Decoder
  import anode_pkg::*;
(
  input  logic [3:0] bcd_i,
  output logic [6:0] seg_o
);

  always_comb begin
    seg_o = SEG_BLANK;
    if (bcd_i <= BCD_MAX) begin
      case (bcd_i)
        4'd0:    seg_o = 7'h40;
        4'd1:    seg_o = 7'h79;
        4'd2:    seg_o = 7'h24;
        4'd3:    seg_o = 7'h30;
        4'd4:    seg_o = 7'h19;
        4'd5:    seg_o = 7'h12;
        4'd6:    seg_o = 7'h02;
        4'd7:    seg_o = 7'h78;
        4'd8:    seg_o = 7'h00;
        4'd9:    seg_o = 7'h10;
        default: seg_o = SEG_BLANK;
      endcase
    end
  end

endmodule

// File: rtl/anode_scan_ctrl.sv
// Time-multiplexed common-anode 7-segment scanner with double-buffered data.
// Define LEADING_ZERO_BLANK_EN to suppress leading zero digits.
module anode_scan_ctrl
  import anode_pkg::*;
#(
  parameter int N_DIGITS     = 4,
  parameter int PRESCALE     = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [N_DIGITS-1:0]   anode_n,
  output logic [6:0]            seg,
  output logic                  frame_start
);

  localparam int CW = $clog2(PRESCALE);
  localparam int IW = $clog2(N_DIGITS);
  localparam logic [CW-1:0]       BLANK_LAST    = CW'(BLANK_CYCLES - 1);
  localparam logic [CW-1:0]       SLOT_LAST     = CW'(PRESCALE - 1);
  localparam logic [IW-1:0]       IDX_LAST      = IW'(N_DIGITS - 1);
  localparam logic [N_DIGITS-1:0] ANODE_ALL_OFF = N_DIGITS'(ANODE_OFF(N_DIGITS));
  localparam logic [N_DIGITS-1:0] ANODE_ONE     = N_DIGITS'(1);

  scan_state_e           state_q;
  logic [CW-1:0]         slotCnt_q;
  logic [IW-1:0]         digitIdx_q;
  logic [N_DIGITS-1:0]   anode_q;
  logic [6:0]            seg_q;
  logic                  frameStart_q;

  logic [4*N_DIGITS-1:0] active_q, active_d;
  logic [4*N_DIGITS-1:0] pendBuf_q, pendBuf_d;
  logic                  pending_q, pending_d;
  logic                  inReady_q, inReady_d;

  logic                  capture;
  logic                  frameEntry;
  logic                  suppress;
  logic [3:0]            activeNibble;
  logic [6:0]            decodedSeg;

  assign capture = in_valid && inReady_q;

  always_comb begin
    frameEntry = 1'b0;
    if (en) begin
      if (state_q == IDLE) begin
        frameEntry = 1'b1;
      end else if (state_q == DRIVE && slotCnt_q == SLOT_LAST && digitIdx_q == IDX_LAST) begin
        frameEntry = 1'b1;
      end
    end
  end

  always_comb begin
    activeNibble = 4'd0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (digitIdx_q == IW'(i)) activeNibble = active_q[4*i +: 4];
    end
  end

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    suppress = 1'b0;
`ifdef LEADING_ZERO_BLANK_EN
    suppress = (digitIdx_q != '0);
    for (int i = 0; i < N_DIGITS; i++) begin
      if (i >= int'(digitIdx_q) && active_q[4*i +: 4] != 4'd0) suppress = 1'b0;
    end
`endif
  end

  BCD_Decoder u_decoder (
    .bcd_i (activeNibble),
    .seg_o (decodedSeg)
  );

  // Pending data moves to the active buffer only at a frame boundary.
  always_comb begin
    pendBuf_d = capture ? in_data : pendBuf_q;
    active_d  = active_q;
    pending_d = pending_q;
    if (frameEntry && pending_q) begin
      active_d  = pendBuf_q;
      pending_d = 1'b0;
    end else if (capture) begin
      pending_d = 1'b1;
    end
    inReady_d = !pending_q && !capture;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q  <= '0;
      pendBuf_q <= '0;
      pending_q <= 1'b0;
      inReady_q <= 1'b1;
    end else begin
      active_q  <= active_d;
      pendBuf_q <= pendBuf_d;
      pending_q <= pending_d;
      inReady_q <= inReady_d;
    end
  end

  // Outputs are loaded on the edge that enters each state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      slotCnt_q    <= '0;
      digitIdx_q   <= '0;
      anode_q      <= ANODE_ALL_OFF;
      seg_q        <= SEG_BLANK;
      frameStart_q <= 1'b0;
    end else begin
      frameStart_q <= frameEntry;
      if (!en) begin
        state_q    <= IDLE;
        slotCnt_q  <= '0;
        digitIdx_q <= '0;
        anode_q    <= ANODE_ALL_OFF;
        seg_q      <= SEG_BLANK;
      end else begin
        case (state_q)
          IDLE: begin
            state_q    <= BLANK;
            slotCnt_q  <= '0;
            digitIdx_q <= '0;
            anode_q    <= ANODE_ALL_OFF;
            seg_q      <= SEG_BLANK;
          end
          BLANK: begin
            slotCnt_q <= slotCnt_q + CW'(1);
            if (slotCnt_q == BLANK_LAST) begin
              state_q <= DRIVE;
              if (suppress) begin
                anode_q <= ANODE_ALL_OFF;
                seg_q   <= SEG_BLANK;
              end else begin
                anode_q <= ~(ANODE_ONE << digitIdx_q);
                seg_q   <= decodedSeg;
              end
            end
          end
          DRIVE: begin
            if (slotCnt_q == SLOT_LAST) begin
              state_q    <= BLANK;
              slotCnt_q  <= '0;
              digitIdx_q <= (digitIdx_q == IDX_LAST) ? '0 : digitIdx_q + IW'(1);
              anode_q    <= ANODE_ALL_OFF;
              seg_q      <= SEG_BLANK;
            end else begin
              slotCnt_q <= slotCnt_q + CW'(1);
            end
          end
          default: begin
            state_q <= IDLE;
            anode_q <= ANODE_ALL_OFF;
            seg_q   <= SEG_BLANK;
          end
        endcase
      end
    end
  end

  assign anode_n     = anode_q;
  assign seg         = seg_q;
  assign frame_start = frameStart_q;
  assign in_ready    = inReady_q;

endmodule
